// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The rd field is sized to the largest supported register-address width.
package pipe_hazard_pkg;

  localparam int HZ_RD_W = 16;
  localparam int FWD_RF  = 0;

  typedef struct packed {
    logic               valid;
    logic               we;
    logic               load;
    logic [HZ_RD_W-1:0] rd;
  } hz_entry_t;

  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_entry_pipe.sv
// hazard_entry_pipe: DEPTH-entry shift register of in-flight register writes.
// Entry 0 takes either the issuing instruction or a bubble; the oldest entry drops out.
module hazard_entry_pipe
  import pipe_hazard_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  bubble_i,
  input  hz_entry_t             entry_i,
  output hz_entry_t [DEPTH-1:0] entries_o
);

  hz_entry_t [DEPTH-1:0] entries_q;
  hz_entry_t [DEPTH-1:0] entries_d;

  // NOTE: a combinational block assigns a default to every output first, so no latch can be inferred.
  always_comb begin
    entries_d    = '0;
    entries_d[0] = bubble_i ? hz_entry_t'('0) : entry_i;
    for (int k = 1; k < DEPTH; k++) begin
      entries_d[k] = entries_q[k-1];
    end
  end

  // NOTE: non-blocking updates let every stage capture its neighbour's pre-edge value.
  // NOTE: whole entries are cleared on reset, so rd/load never feed X into the compares.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      entries_q <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

  assign entries_o = entries_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: decode stall, operand forwarding selects and branch flush.
// Define HAZARD_FWD_EN for forwarding with load-use stalls; otherwise any RAW stalls.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int REG_AW     = 4,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int CNT_W      = 32
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          issue_valid_i,
  input  logic                          issue_we_i,
  input  logic                          issue_load_i,
  input  logic [REG_AW-1:0]             issue_rd_i,
  input  logic                          src1_used_i,
  input  logic [REG_AW-1:0]             src1_addr_i,
  input  logic                          src2_used_i,
  input  logic [REG_AW-1:0]             src2_addr_i,
  input  logic                          branch_i,
  output logic                          stall_o,
  output logic                          flush_o,
  output logic [sel_width(DEPTH)-1:0]   fwd1_sel_o,
  output logic [sel_width(DEPTH)-1:0]   fwd2_sel_o,
  output logic [CNT_W-1:0]              stall_cnt_o
);

  localparam int SEL_W = sel_width(DEPTH);

  typedef struct packed {
    logic             hazard;
    logic [SEL_W-1:0] sel;
  } src_res_t;

  hz_entry_t [DEPTH-1:0] tracker;
  hz_entry_t             issue_entry;
  logic                  bubble;
  src_res_t              res1;
  src_res_t              res2;
  logic                  stall;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;

  function automatic logic src_match(input hz_entry_t e, input logic used,
                                     input logic [REG_AW-1:0] addr);
    return used && e.valid && e.we && (e.rd == HZ_RD_W'(addr));
  endfunction

  function automatic src_res_t resolve_src(input logic used, input logic [REG_AW-1:0] addr,
                                           input hz_entry_t [DEPTH-1:0] ents);
    src_res_t r;
`ifdef HAZARD_FWD_EN
    logic hit;
    logic hit_load;
    int   hit_idx;
`endif
    r.hazard = 1'b0;
    r.sel    = SEL_W'(FWD_RF);
`ifdef HAZARD_FWD_EN
    hit      = 1'b0;
    hit_load = 1'b0;
    hit_idx  = 0;
    // Scan oldest to youngest so the youngest producer is the one left standing.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (src_match(ents[k], used, addr)) begin
        hit      = 1'b1;
        hit_load = ents[k].load;
        hit_idx  = k;
      end
    end
    if (hit) begin
      if (hit_load && (hit_idx < LOAD_STAGE)) begin
        r.hazard = 1'b1;
      end else begin
        r.sel = SEL_W'(hit_idx + 1);
      end
    end
`else
    // The last entry is skipped: the register file writes through in that cycle.
    for (int k = 0; k < DEPTH - 1; k++) begin
      if (src_match(ents[k], used, addr)) begin
        r.hazard = 1'b1;
      end
    end
`endif
    return r;
  endfunction

`ifndef HAZARD_FWD_EN
  logic unused_fwd_cfg;
  assign unused_fwd_cfg = LOAD_STAGE[0];
`endif

  always_comb begin
    res1  = resolve_src(src1_used_i, src1_addr_i, tracker);
    res2  = resolve_src(src2_used_i, src2_addr_i, tracker);
    // A taken branch kills the decode instruction, so its hazard is moot.
    stall = (res1.hazard | res2.hazard) & ~branch_i;
  end

  always_comb begin
    issue_entry.valid = 1'b1;
    issue_entry.we    = issue_we_i;
    issue_entry.load  = issue_load_i;
    issue_entry.rd    = HZ_RD_W'(issue_rd_i);
    bubble            = stall | branch_i | ~issue_valid_i;
  end

  hazard_entry_pipe #(
    .DEPTH(DEPTH)
  ) u_entry_pipe (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .bubble_i (bubble),
    .entry_i  (issue_entry),
    .entries_o(tracker)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (stall && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_o     = stall;
  assign flush_o     = branch_i;
  assign fwd1_sel_o  = res1.sel;
  assign fwd2_sel_o  = res2.sel;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl; expectations follow HAZARD_FWD_EN.
module tb_pipe_hazard_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 3;
  localparam int LS    = 1;
  localparam int CW    = 4;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          issue_valid_i, issue_we_i, issue_load_i;
  logic [AW-1:0] issue_rd_i;
  logic          src1_used_i, src2_used_i;
  logic [AW-1:0] src1_addr_i, src2_addr_i;
  logic          branch_i;
  logic          stall_o, flush_o;
  logic [1:0]    fwd1_sel_o, fwd2_sel_o;
  logic [CW-1:0] stall_cnt_o;

  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl #(
    .REG_AW(AW), .DEPTH(DEPTH), .LOAD_STAGE(LS), .CNT_W(CW)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .issue_valid_i(issue_valid_i), .issue_we_i(issue_we_i), .issue_load_i(issue_load_i),
    .issue_rd_i(issue_rd_i),
    .src1_used_i(src1_used_i), .src1_addr_i(src1_addr_i),
    .src2_used_i(src2_used_i), .src2_addr_i(src2_addr_i),
    .branch_i(branch_i),
    .stall_o(stall_o), .flush_o(flush_o),
    .fwd1_sel_o(fwd1_sel_o), .fwd2_sel_o(fwd2_sel_o),
    .stall_cnt_o(stall_cnt_o)
  );

  typedef struct {
    logic          stall;
    logic          flush;
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [CW-1:0] cnt;
    string         name;
  } exp_t;

  exp_t          sb[$];
  int            checks    = 0;
  int            failures  = 0;
  logic [CW-1:0] model_cnt = '0;

  // Drive one decode cycle and queue what the outputs must show in it.
  task automatic drive(input logic v, input logic we, input logic ld, input logic [AW-1:0] rd,
                       input logic u1, input logic [AW-1:0] a1,
                       input logic u2, input logic [AW-1:0] a2,
                       input logic br, input logic es, input logic [1:0] e1, input logic [1:0] e2,
                       input string nm);
    exp_t e;
    issue_valid_i = v;  issue_we_i  = we; issue_load_i = ld; issue_rd_i = rd;
    src1_used_i   = u1; src1_addr_i = a1;
    src2_used_i   = u2; src2_addr_i = a2;
    branch_i      = br;
    e.stall = es; e.flush = br; e.s1 = e1; e.s2 = e2; e.cnt = model_cnt; e.name = nm;
    sb.push_back(e);
    if (reset_i) model_cnt = '0;
    else if (es && model_cnt != '1) model_cnt = model_cnt + 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic idle(input string nm);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, nm);
  endtask

  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if (stall_o !== e.stall) begin
        failures++; $display("FAIL %s stall_o got=%b exp=%b", e.name, stall_o, e.stall);
      end
      checks++;
      if (flush_o !== e.flush) begin
        failures++; $display("FAIL %s flush_o got=%b exp=%b", e.name, flush_o, e.flush);
      end
      checks++;
      if (fwd1_sel_o !== e.s1) begin
        failures++; $display("FAIL %s fwd1_sel_o got=%0d exp=%0d", e.name, fwd1_sel_o, e.s1);
      end
      checks++;
      if (fwd2_sel_o !== e.s2) begin
        failures++; $display("FAIL %s fwd2_sel_o got=%0d exp=%0d", e.name, fwd2_sel_o, e.s2);
      end
      checks++;
      if (stall_cnt_o !== e.cnt) begin
        failures++; $display("FAIL %s stall_cnt_o got=%0d exp=%0d", e.name, stall_cnt_o, e.cnt);
      end
    end
  end

  task automatic test_reset();
    reset_i = 1'b1;
    issue_valid_i = 0; issue_we_i = 0; issue_load_i = 0; issue_rd_i = '0;
    src1_used_i = 1; src1_addr_i = 4'd0; src2_used_i = 1; src2_addr_i = 4'd0; branch_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if (stall_o !== 1'b0 || fwd1_sel_o !== 2'd0 || fwd2_sel_o !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs stall=%b sel1=%0d sel2=%0d exp 0/0/0", stall_o, fwd1_sel_o, fwd2_sel_o);
    end
    checks++;
    if (stall_cnt_o !== '0) begin
      failures++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt_o);
    end
    reset_i   = 1'b0;
    model_cnt = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, "reset_branch");
  endtask

  task automatic drain();
    repeat (3) idle("drain");
  endtask

  task automatic test_raw_alu();
    drive(1, 1, 0, 4'd1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, "add_r1");
`ifdef HAZARD_FWD_EN
    drive(1, 1, 0, 4'd2, 1, 4'd1, 1, 4'd3, 0, 0, 2'd1, 2'd0, "sub_fwd");
    drive(1, 1, 0, 4'd5, 1, 4'd2, 0, 0,    0, 0, 2'd1, 2'd0, "chain_fwd");
`else
    drive(1, 1, 0, 4'd2, 1, 4'd1, 1, 4'd3, 0, 1, 2'd0, 2'd0, "sub_stall0");
    drive(1, 1, 0, 4'd2, 1, 4'd1, 1, 4'd3, 0, 1, 2'd0, 2'd0, "sub_stall1");
    drive(1, 1, 0, 4'd2, 1, 4'd1, 1, 4'd3, 0, 0, 2'd0, 2'd0, "sub_issue");
    drive(1, 1, 0, 4'd5, 1, 4'd2, 0, 0,    0, 1, 2'd0, 2'd0, "chain_stall0");
    drive(1, 1, 0, 4'd5, 1, 4'd2, 0, 0,    0, 1, 2'd0, 2'd0, "chain_stall1");
    drive(1, 1, 0, 4'd5, 1, 4'd2, 0, 0,    0, 0, 2'd0, 2'd0, "chain_issue");
`endif
    drain();
  endtask

  task automatic test_load_use();
    drive(1, 1, 1, 4'd4, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, "ldr_r4");
`ifdef HAZARD_FWD_EN
    drive(1, 1, 0, 4'd5, 1, 4'd4, 1, 4'd4, 0, 1, 2'd0, 2'd0, "ldr_use_stall");
    drive(1, 1, 0, 4'd5, 1, 4'd4, 1, 4'd4, 0, 0, 2'd2, 2'd2, "ldr_use_fwd");
`else
    drive(1, 1, 0, 4'd5, 1, 4'd4, 1, 4'd4, 0, 1, 2'd0, 2'd0, "ldr_use_stall0");
    drive(1, 1, 0, 4'd5, 1, 4'd4, 1, 4'd4, 0, 1, 2'd0, 2'd0, "ldr_use_stall1");
    drive(1, 1, 0, 4'd5, 1, 4'd4, 1, 4'd4, 0, 0, 2'd0, 2'd0, "ldr_use_issue");
`endif
    drain();
  endtask

  task automatic test_youngest();
    drive(1, 1, 0, 4'd1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, "w_r1_old");
    drive(1, 1, 0, 4'd6, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, "w_r6");
    drive(1, 1, 0, 4'd1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, "w_r1_new");
`ifdef HAZARD_FWD_EN
    drive(1, 0, 0, 0, 1, 4'd1, 1, 4'd6, 0, 0, 2'd1, 2'd2, "young_fwd");
`else
    drive(1, 0, 0, 0, 1, 4'd1, 1, 4'd6, 0, 1, 2'd0, 2'd0, "young_stall0");
    drive(1, 0, 0, 0, 1, 4'd1, 1, 4'd6, 0, 1, 2'd0, 2'd0, "young_stall1");
    drive(1, 0, 0, 0, 1, 4'd1, 1, 4'd6, 0, 0, 2'd0, 2'd0, "young_issue");
`endif
    drain();
  endtask

  task automatic test_branch_load();
    drive(1, 1, 1, 4'd4, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, "br_ldr_r4");
    drive(1, 1, 0, 4'd4, 1, 4'd4, 0, 0, 1, 0, 2'd0, 2'd0, "br_with_hazard");
`ifdef HAZARD_FWD_EN
    drive(1, 0, 0, 0, 1, 4'd4, 0, 0, 0, 0, 2'd2, 2'd0, "post_flush_fwd");
`else
    drive(1, 0, 0, 0, 1, 4'd4, 0, 0, 0, 1, 2'd0, 2'd0, "post_flush_stall");
    drive(1, 0, 0, 0, 1, 4'd4, 0, 0, 0, 0, 2'd0, 2'd0, "post_flush_issue");
`endif
    drain();
  endtask

  task automatic test_filters();
    drive(0, 1, 0, 4'd8, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, "invalid_w_r8");
    drive(1, 0, 0, 0, 1, 4'd8, 0, 0, 0, 0, 2'd0, 2'd0, "invalid_no_match");
    drive(1, 0, 0, 4'd9, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, "nowe_r9");
    drive(1, 0, 0, 0, 0, 0, 1, 4'd9, 0, 0, 2'd0, 2'd0, "nowe_no_match");
    drive(1, 1, 0, 4'd10, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, "w_r10");
    drive(1, 0, 0, 0, 0, 4'd10, 1, 4'd11, 0, 0, 2'd0, 2'd0, "unused_mismatch");
`ifdef HAZARD_FWD_EN
    drive(1, 0, 0, 0, 1, 4'd10, 0, 0, 0, 0, 2'd2, 2'd0, "r10_fwd");
`else
    drive(1, 0, 0, 0, 1, 4'd10, 0, 0, 0, 1, 2'd0, 2'd0, "r10_stall");
    drive(1, 0, 0, 0, 1, 4'd10, 0, 0, 0, 0, 2'd0, 2'd0, "r10_issue");
`endif
    drain();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 1, 4'd13, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, "sat_ldr");
`ifdef HAZARD_FWD_EN
      drive(1, 0, 0, 0, 1, 4'd13, 0, 0, 0, 1, 2'd0, 2'd0, "sat_stall");
      drive(1, 0, 0, 0, 1, 4'd13, 0, 0, 0, 0, 2'd2, 2'd0, "sat_issue");
`else
      drive(1, 0, 0, 0, 1, 4'd13, 0, 0, 0, 1, 2'd0, 2'd0, "sat_stall0");
      drive(1, 0, 0, 0, 1, 4'd13, 0, 0, 0, 1, 2'd0, 2'd0, "sat_stall1");
      drive(1, 0, 0, 0, 1, 4'd13, 0, 0, 0, 0, 2'd0, 2'd0, "sat_issue");
`endif
    end
    checks++;
    if (stall_cnt_o !== 4'hF) begin
      failures++; $display("FAIL cnt_saturated got=%0h exp=f", stall_cnt_o);
    end
    drive(1, 1, 1, 4'd14, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, "rst_ldr_r14");
    reset_i = 1'b1;
    drive(1, 0, 0, 0, 1, 4'd14, 0, 0, 0, 1, 2'd0, 2'd0, "rst_mid_stall");
    reset_i = 1'b0;
    drive(1, 0, 0, 0, 1, 4'd14, 0, 0, 0, 0, 2'd0, 2'd0, "after_rst");
    checks++;
    if (stall_cnt_o !== '0) begin
      failures++; $display("FAIL cnt_after_rst got=%0d exp=0", stall_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_raw_alu();
    test_load_use();
    test_youngest();
    test_branch_load();
    test_filters();
    test_saturation();
    idle("final");
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and pipeline-control unit for the in-order ARM pipeline (fetch → decode → execute → mem → write_back). It tracks every in-flight register write from execute to write-back and produces three things: the decode stall, the per-source forwarding selects, and the branch flush. This replaces the ad-hoc stall/flush wiring between stages with one configurable block, scalable in register-address width and tracked depth.

## Interface
Parameters:
- REG_AW, 4: register address width.
- DEPTH, 3: number of tracked stages after decode (entry 0 = execute, DEPTH-1 = write-back); minimum 2.
- LOAD_STAGE, 1: entry index whose output first carries load data; a load in entries < LOAD_STAGE is not forwardable.
- CNT_W, 32: stall counter width.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - clk_i  in  1  clock.
  - reset_i  in  1  synchronous active-high reset.
- Issue side, from decode:
  - issue_valid_i  in  1  decode holds a valid instruction.
  - issue_we_i  in  1  instruction writes rd.
  - issue_load_i  in  1  instruction is a load.
  - issue_rd_i  in  REG_AW  destination register.
  - src1_used_i / src2_used_i  in  1  source operand is read.
  - src1_addr_i / src2_addr_i  in  REG_AW  source registers.
- Branch, from execute:
  - branch_i  in  1  taken branch resolved in execute this cycle.
- Outputs:
  - stall_o  out  1  hold fetch/decode and insert a bubble into execute.
  - flush_o  out  1  invalidate fetch and decode contents.
  - fwd1_sel_o / fwd2_sel_o  out  $clog2(DEPTH+1)  0 = register file, k = result of entry k-1.
  - stall_cnt_o  out  CNT_W  saturating count of stall cycles.

## Operation
- Tracker: DEPTH entries of {valid, we, load, rd}. Each clock, entries shift up by one and the entry leaving DEPTH-1 is dropped.
- Entry 0 loads as follows:
  - A bubble (valid=0) if stall_o, flush_o or !issue_valid_i.
  - Otherwise the issue_* fields.
- Match for a source: src_used && entry.valid && entry.we && entry.rd == src_addr.
- Forwarding (feature enabled):
  - The select takes the lowest-index matching entry (youngest wins).
  - With no match, the select is 0.
  - A load-use hazard exists when the youngest match is a load at index < LOAD_STAGE. It asserts stall_o and drives the select to 0.
- Branch priority:
  - flush_o = branch_i.
  - When branch_i is high, stall_o is forced 0, because the decode instruction is being flushed.
  - The instruction currently in execute stays valid in the tracker.
- stall_cnt_o:
  - Increments on every cycle with stall_o=1.
  - Holds at all-ones.
- Entries are not cleared by stall; they keep draining, which guarantees forward progress.

## Timing
- stall_o, flush_o and fwd*_sel_o are combinational from the current tracker state and this cycle's inputs; there is zero latency.
- The tracker and the counter update on the rising edge of clk_i.
- A load-use stall lasts LOAD_STAGE cycles.
- Reset behaviour:
  - Reset clears every tracker entry to invalid and stall_cnt_o to 0.
  - Consequently, in the cycle after reset, stall_o=0, flush_o=branch_i and both selects are 0.
  - Reset asserted mid-stall aborts the stall on the next edge.
- Simultaneous branch_i and hazard: flush wins, with no stall and no counter increment.
- A source that matches nothing, or has src_used=0, always selects 0.

## Configuration
- HAZARD_FWD_EN defined: forwarding as described; only load-use stalls.
- HAZARD_FWD_EN undefined:
  - fwd*_sel_o are tied to 0.
  - stall_o asserts on any match in entries 0..DEPTH-2, whether or not the producer is a load.
  - Entry DEPTH-1 is excluded because the register file write-back is write-through.

## Structure
- Package pipe_hazard_pkg holds:
  - The hz_entry_t struct {valid, we, load, rd}.
  - The FWD_RF = 0 constant.
  - A function computing the select width.
- Sub-module hazard_entry_pipe: the DEPTH-entry shift register with the bubble-insert input and synchronous reset.
- The top level adds match/priority logic, stall/flush generation and the counter.

## Test plan
- Reset, then issue ADD r1 followed by SUB r2,r1,r3 with forwarding: stall_o=0 and fwd1_sel_o=1 on the SUB.
- LDR r4 followed by ADD r5,r4,r4 (LOAD_STAGE=1):
  - One cycle with stall_o=1 and entry 0 a bubble.
  - Then fwd1_sel_o=fwd2_sel_o=2.
  - stall_cnt_o=1.
- Writes to r1 at entries 0 and 2 (distinct issues), then read r1: fwd1_sel_o=1 (youngest wins).
- branch_i asserted together with a load-use hazard: flush_o=1, stall_o=0, stall_cnt_o unchanged, and entry 0 is a bubble next cycle.
- Without HAZARD_FWD_EN, ADD r1 then read r1: stall_o=1 for 2 cycles (DEPTH=3), then the read issues with fwd1_sel_o=0.
- Force stall_cnt_o to 0xFFFF_FFFF, then stall: it stays 0xFFFF_FFFF. Assert reset_i mid-stall: the next cycle gives stall_o=0 and stall_cnt_o=0.
